// File: rtl/axi_isolate_seq.sv
// Shutdown/bring-up sequencer for a downstream AXI subdomain: drives the isolation stage,
// the domain clock gate and the domain reset in a fixed order, with a drain timeout flag.
module axi_isolate_seq #(
    parameter int unsigned ResetCycles    = 4,
    parameter int unsigned GateCycles     = 2,
    parameter int unsigned TimeoutCycles  = 256,
    parameter bit          ForceOnTimeout = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic power_req_i,
    input  logic isolated_i,
    input  logic err_clr_i,
    output logic isolate_o,
    output logic clk_en_o,
    output logic dom_rst_o,
    output logic on_o,
    output logic off_o,
    output logic timeout_o
);

    localparam int unsigned MaxRG     = (ResetCycles > GateCycles) ? ResetCycles : GateCycles;
    localparam int unsigned MaxCycles = (MaxRG > TimeoutCycles) ? MaxRG : TimeoutCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] RstLast  = CntW'(ResetCycles - 1);
    localparam logic [CntW-1:0] GateLast = CntW'(GateCycles - 1);
    localparam logic [CntW-1:0] ToLast   = CntW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_UNGATE,
        S_RELEASE,
        S_ACTIVE,
        S_ISOLATING,
        S_GATING
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
    logic            r_timeout;
    logic            w_to_set;
    logic            w_timed;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_OFF;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_to_set) begin
                r_timeout <= 1'b1;
            end else if (err_clr_i) begin
                r_timeout <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_to_set    = 1'b0;
        w_timed     = 1'b0;
        case (r_state)
            S_OFF: begin
                if (power_req_i) w_state_nxt = S_UNGATE;
            end
            S_UNGATE: begin
                w_timed = 1'b1;
                if (r_cnt == RstLast) w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!power_req_i) w_state_nxt = S_ISOLATING;
            end
            S_ISOLATING: begin
                w_timed = 1'b1;
                // Abort outranks drain completion, which outranks the timeout.
                if (power_req_i) begin
                    w_state_nxt = S_ACTIVE;
                end else if (isolated_i) begin
                    w_state_nxt = S_GATING;
                end else if (r_cnt == ToLast) begin
                    w_to_set = 1'b1;
                    w_timed  = 1'b0;
                    if (ForceOnTimeout) w_state_nxt = S_GATING;
                end
            end
            S_GATING: begin
                w_timed = 1'b1;
                if (r_cnt == GateLast) w_state_nxt = S_OFF;
            end
            default: begin
                w_state_nxt = S_OFF;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if (w_timed) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    always_comb begin
        isolate_o = 1'b1;
        clk_en_o  = 1'b0;
        dom_rst_o = 1'b1;
        case (r_state)
            S_OFF:       {isolate_o, clk_en_o, dom_rst_o} = 3'b101;
            S_UNGATE:    {isolate_o, clk_en_o, dom_rst_o} = 3'b111;
            S_RELEASE:   {isolate_o, clk_en_o, dom_rst_o} = 3'b110;
            S_ACTIVE:    {isolate_o, clk_en_o, dom_rst_o} = 3'b010;
            S_ISOLATING: {isolate_o, clk_en_o, dom_rst_o} = 3'b110;
            S_GATING:    {isolate_o, clk_en_o, dom_rst_o} = 3'b100;
            default:     {isolate_o, clk_en_o, dom_rst_o} = 3'b101;
        endcase
    end

    assign on_o      = (r_state == S_ACTIVE);
    assign off_o     = (r_state == S_OFF);
    assign timeout_o = r_timeout;

    // An unisolated port must always see a running clock and a released domain.
    a_clk_while_open: assert property (@(posedge clk_i) disable iff (rst_i) isolate_o || clk_en_o);
    a_rst_while_open: assert property (@(posedge clk_i) disable iff (rst_i) isolate_o || !dom_rst_o);

endmodule

// File: tb/tb_axi_isolate_seq.sv
// Scoreboard bench for axi_isolate_seq: two instances (wait vs. force on timeout) share stimulus.
module tb_axi_isolate_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pr = 1'b0;
    logic isol = 1'b0;
    logic clr = 1'b0;

    logic iso0, ce0, dr0, on0, off0, to0;
    logic iso1, ce1, dr1, on1, off1, to1;
    logic [5:0] obs0, obs1;

    int n_vec = 0;
    int n_err = 0;
    logic [5:0] scb[$];

    // Expected output vectors: {isolate, clk_en, dom_rst, on, off, timeout}
    localparam logic [5:0] V_OFF = 6'b101010;
    localparam logic [5:0] V_UNG = 6'b111000;
    localparam logic [5:0] V_REL = 6'b110000;
    localparam logic [5:0] V_ACT = 6'b010100;
    localparam logic [5:0] V_ISO = 6'b110000;
    localparam logic [5:0] V_GAT = 6'b100000;
    localparam logic [5:0] TO    = 6'b000001;

    axi_isolate_seq #(.ResetCycles(4), .GateCycles(2), .TimeoutCycles(8), .ForceOnTimeout(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .power_req_i(pr), .isolated_i(isol), .err_clr_i(clr),
        .isolate_o(iso0), .clk_en_o(ce0), .dom_rst_o(dr0), .on_o(on0), .off_o(off0), .timeout_o(to0)
    );

    axi_isolate_seq #(.ResetCycles(4), .GateCycles(2), .TimeoutCycles(8), .ForceOnTimeout(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .power_req_i(pr), .isolated_i(isol), .err_clr_i(clr),
        .isolate_o(iso1), .clk_en_o(ce1), .dom_rst_o(dr1), .on_o(on1), .off_o(off1), .timeout_o(to1)
    );

    assign obs0 = {iso0, ce0, dr0, on0, off0, to0};
    assign obs1 = {iso1, ce1, dr1, on1, off1, to1};

    always #5 clk = ~clk;

    function automatic logic [8:0] row(int p, int i, int c, logic [5:0] e);
        return {p[0], i[0], c[0], e};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            n_vec++;
            if ((!iso0 && (!ce0 || dr0)) || (!iso1 && (!ce1 || dr1))) begin
                n_err++;
                $display("FAIL invariant: dut0 iso/ce/rst=%b%b%b dut1 iso/ce/rst=%b%b%b (open port needs clk_en=1 rst=0)",
                         iso0, ce0, dr0, iso1, ce1, dr1);
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        #1;
        n_vec += 2;
        if (obs0 !== V_OFF) begin n_err++; $display("FAIL reset_async dut0: got %b want %b", obs0, V_OFF); end
        if (obs1 !== V_OFF) begin n_err++; $display("FAIL reset_async dut1: got %b want %b", obs1, V_OFF); end
        tick;
        @(negedge clk) rst = 1'b0;
        tick;
        n_vec++;
        if (obs0 !== V_OFF) begin n_err++; $display("FAIL reset_idle: got %b want %b", obs0, V_OFF); end
    endtask

    task automatic test_power_up(input bit sel);
        logic [8:0] t[$];
        logic [5:0] got, e;
        t = '{row(1,0,0,V_UNG), row(1,0,0,V_UNG), row(1,0,0,V_UNG), row(1,0,0,V_UNG),
              row(1,0,0,V_REL), row(1,0,0,V_ACT), row(1,0,0,V_ACT)};
        foreach (t[k]) begin
            {pr, isol, clr} = t[k][8:6];
            scb.push_back(t[k][5:0]);
            tick;
            got = sel ? obs1 : obs0;
            e = scb.pop_front();
            n_vec++;
            if (got !== e) begin n_err++; $display("FAIL power_up[%0d] dut%0d: got %b want %b", k, sel, got, e); end
        end
    endtask

    task automatic test_shutdown;
        logic [8:0] t[$];
        logic [5:0] e;
        t = '{row(0,0,0,V_ISO), row(0,0,0,V_ISO), row(0,0,0,V_ISO), row(0,1,0,V_GAT),
              row(0,1,0,V_GAT), row(0,0,0,V_OFF), row(0,0,0,V_OFF)};
        foreach (t[k]) begin
            {pr, isol, clr} = t[k][8:6];
            scb.push_back(t[k][5:0]);
            tick;
            e = scb.pop_front();
            n_vec++;
            if (obs0 !== e) begin n_err++; $display("FAIL shutdown[%0d]: got %b want %b", k, obs0, e); end
        end
    endtask

    task automatic test_toggle;
        logic [8:0] t[$];
        logic [5:0] e;
        t = '{row(1,0,0,V_UNG), row(0,0,0,V_UNG), row(0,0,0,V_UNG), row(0,0,0,V_UNG),
              row(0,0,0,V_REL), row(0,0,0,V_ACT), row(0,0,0,V_ISO), row(0,1,0,V_GAT),
              row(0,0,0,V_GAT), row(0,0,0,V_OFF)};
        foreach (t[k]) begin
            {pr, isol, clr} = t[k][8:6];
            scb.push_back(t[k][5:0]);
            tick;
            e = scb.pop_front();
            n_vec++;
            if (obs0 !== e) begin n_err++; $display("FAIL toggle[%0d]: got %b want %b", k, obs0, e); end
        end
    endtask

    task automatic test_abort;
        logic [8:0] t[$];
        logic [5:0] e;
        t = '{row(0,0,0,V_ISO), row(1,1,0,V_ACT), row(1,0,0,V_ACT)};
        foreach (t[k]) begin
            {pr, isol, clr} = t[k][8:6];
            scb.push_back(t[k][5:0]);
            tick;
            e = scb.pop_front();
            n_vec++;
            if (obs0 !== e) begin n_err++; $display("FAIL abort[%0d]: got %b want %b", k, obs0, e); end
        end
    endtask

    task automatic test_timeout_hold;
        logic [8:0] t[$];
        logic [5:0] e;
        t = '{row(0,0,0,V_ISO), row(0,0,0,V_ISO), row(0,0,0,V_ISO), row(0,0,0,V_ISO),
              row(0,0,0,V_ISO), row(0,0,0,V_ISO), row(0,0,0,V_ISO), row(0,0,0,V_ISO),
              row(0,0,0,V_ISO|TO), row(0,0,1,V_ISO|TO), row(0,0,0,V_ISO|TO),
              row(0,1,0,V_GAT|TO), row(0,0,0,V_GAT|TO), row(0,0,0,V_OFF|TO),
              row(0,0,1,V_OFF), row(0,0,0,V_OFF)};
        foreach (t[k]) begin
            {pr, isol, clr} = t[k][8:6];
            scb.push_back(t[k][5:0]);
            tick;
            e = scb.pop_front();
            n_vec++;
            if (obs0 !== e) begin n_err++; $display("FAIL timeout_hold[%0d]: got %b want %b", k, obs0, e); end
        end
    endtask

    task automatic test_timeout_force;
        logic [8:0] t[$];
        logic [5:0] e;
        t = '{row(0,0,0,V_ISO), row(0,0,0,V_ISO), row(0,0,0,V_ISO), row(0,0,0,V_ISO),
              row(0,0,0,V_ISO), row(0,0,0,V_ISO), row(0,0,0,V_ISO), row(0,0,0,V_ISO),
              row(0,0,0,V_GAT|TO), row(0,0,0,V_GAT|TO), row(0,0,0,V_OFF|TO), row(0,0,1,V_OFF)};
        foreach (t[k]) begin
            {pr, isol, clr} = t[k][8:6];
            scb.push_back(t[k][5:0]);
            tick;
            e = scb.pop_front();
            n_vec++;
            if (obs1 !== e) begin n_err++; $display("FAIL timeout_force[%0d]: got %b want %b", k, obs1, e); end
        end
    endtask

    task automatic test_reset_mid;
        {pr, isol, clr} = 3'b000;
        rst = 1'b1;
        #1;
        n_vec++;
        if (obs0 !== V_OFF) begin n_err++; $display("FAIL reset_clears_timeout: got %b want %b", obs0, V_OFF); end
        @(negedge clk) rst = 1'b0;
        pr = 1'b1;
        tick;
        tick;
        n_vec++;
        if (obs0 !== V_UNG) begin n_err++; $display("FAIL reset_mid_pre_ungate: got %b want %b", obs0, V_UNG); end
        #2 rst = 1'b1;
        #1;
        n_vec += 2;
        if (obs0 !== V_OFF) begin n_err++; $display("FAIL reset_mid_ungate dut0: got %b want %b", obs0, V_OFF); end
        if (obs1 !== V_OFF) begin n_err++; $display("FAIL reset_mid_ungate dut1: got %b want %b", obs1, V_OFF); end
        @(negedge clk) rst = 1'b0;
        repeat (6) tick;
        n_vec++;
        if (obs0 !== V_ACT) begin n_err++; $display("FAIL reset_mid_reup: got %b want %b", obs0, V_ACT); end
        pr = 1'b0;
        tick;
        isol = 1'b1;
        tick;
        n_vec++;
        if (obs0 !== V_GAT) begin n_err++; $display("FAIL reset_mid_pre_gating: got %b want %b", obs0, V_GAT); end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (obs0 !== V_OFF) begin n_err++; $display("FAIL reset_mid_gating: got %b want %b", obs0, V_OFF); end
        @(negedge clk) begin
            rst = 1'b0;
            isol = 1'b0;
        end
        tick;
        n_vec++;
        if (obs0 !== V_OFF) begin n_err++; $display("FAIL reset_mid_after: got %b want %b", obs0, V_OFF); end
    endtask

    initial begin
        test_reset;
        test_power_up(1'b0);
        test_shutdown;
        test_toggle;
        test_power_up(1'b0);
        test_abort;
        test_timeout_hold;
        rst = 1'b1;
        #1;
        @(negedge clk) rst = 1'b0;
        test_power_up(1'b1);
        test_timeout_force;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
